alarm_tone_generator: RTL and testbench

Generates the alarm's beeping square-wave tone as signed 32-bit PCM samples and feeds them to `Audio_Controller`, sitting directly upstream of it. Output rate is set by the controller's FIFO backpressure (`audio_out_allowed`): one sample per accepted write, so all tone timing is counted in samples (48 kHz DAC rate). The alarm FSM drives `enable`. When the alarm stops, the block flushes the controller's output FIFO so sound ends promptly.

---
 rtl/alarm_tone_generator.sv | 141 ++++++++++++++
 tb/tb_alarm_tone_generator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alarm_tone_generator.sv
// Alarm beep generator: streams a gated square wave as signed PCM samples into
// the audio controller FIFO, one sample per accepted write, and flushes the FIFO on stop.
module alarm_tone_generator #(
    parameter logic [31:0] AMPLITUDE        = 32'h1000_0000,
    parameter int unsigned BEEP_ON_SAMPLES  = 12000,
    parameter int unsigned BEEP_OFF_SAMPLES = 12000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] half_period,
    input  logic [1:0]  volume,
    input  logic        audio_out_allowed,
    output logic        write_audio_out,
    output logic [31:0] left_channel_audio_out,
    output logic [31:0] right_channel_audio_out,
    output logic        clear_audio_out_memory,
    output logic        beeping
);

    localparam int unsigned BEEP_MAX = (BEEP_ON_SAMPLES > BEEP_OFF_SAMPLES) ?
                                       BEEP_ON_SAMPLES : BEEP_OFF_SAMPLES;
    localparam int BEEP_W = ($clog2(BEEP_MAX + 1) > 14) ? $clog2(BEEP_MAX + 1) : 14;
    localparam logic [BEEP_W-1:0] ON_LAST  = BEEP_W'(BEEP_ON_SAMPLES - 1);
    localparam logic [BEEP_W-1:0] OFF_LAST = BEEP_W'(BEEP_OFF_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state, state_next;
    logic              polarity, polarity_next;
    logic [15:0]       hp, hp_next;
    logic [1:0]        vol, vol_next;
    logic [15:0]       phase_cnt, phase_next;
    logic [BEEP_W-1:0] beep_cnt, beep_next;
    logic              clear_q, clear_next;
    logic [31:0]       peak;
    logic [31:0]       sample;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            polarity  <= 1'b1;
            hp        <= 16'd1;
            vol       <= 2'd0;
            phase_cnt <= '0;
            beep_cnt  <= '0;
            clear_q   <= 1'b0;
        end else begin
            state     <= state_next;
            polarity  <= polarity_next;
            hp        <= hp_next;
            vol       <= vol_next;
            phase_cnt <= phase_next;
            beep_cnt  <= beep_next;
            clear_q   <= clear_next;
        end
    end

    always_comb begin
        state_next      = state;
        polarity_next   = polarity;
        hp_next         = hp;
        vol_next        = vol;
        phase_next      = phase_cnt;
        beep_next       = beep_cnt;
        clear_next      = 1'b0;
        write_audio_out = (state != IDLE) && audio_out_allowed;

        // Dropping enable wins over every other transition and arms the flush.
        if (!enable) begin
            state_next = IDLE;
            clear_next = (state != IDLE);
            phase_next = '0;
            beep_next  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_next    = TONE;
                    hp_next       = (half_period == 16'd0) ? 16'd1 : half_period;
                    vol_next      = volume;
                    polarity_next = 1'b1;
                    phase_next    = '0;
                    beep_next     = '0;
                end
                TONE: begin
                    if (write_audio_out) begin
                        if (phase_cnt == hp - 16'd1) begin
                            phase_next    = '0;
                            polarity_next = ~polarity;
                        end else begin
                            phase_next = phase_cnt + 16'd1;
                        end
                        if (beep_cnt == ON_LAST) begin
                            state_next = GAP;
                            beep_next  = '0;
                        end else begin
                            beep_next = beep_cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (write_audio_out) begin
                        if (beep_cnt == OFF_LAST) begin
                            // Re-entry to TONE re-latches the burst settings.
                            state_next    = TONE;
                            hp_next       = (half_period == 16'd0) ? 16'd1 : half_period;
                            vol_next      = volume;
                            polarity_next = 1'b1;
                            phase_next    = '0;
                            beep_next     = '0;
                        end else begin
                            beep_next = beep_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        peak = AMPLITUDE >> (2'd3 - vol);
        if (state == TONE) begin
            sample = polarity ? peak : (32'd0 - peak);
        end else begin
            sample = 32'd0;
        end
    end

    assign left_channel_audio_out  = sample;
    assign right_channel_audio_out = sample;
    assign clear_audio_out_memory  = clear_q;
    assign beeping                 = (state == TONE);

endmodule

// File: tb/tb_alarm_tone_generator.sv
// Directed bench for alarm_tone_generator: expected samples are queued as stimulus
// is applied and popped on each observed write.
module tb_alarm_tone_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] half_period;
    logic [1:0]  volume;
    logic        allowed;
    logic        write_audio_out;
    logic [31:0] left_out;
    logic [31:0] right_out;
    logic        clear_out;
    logic        beeping;

    int          total_cnt  = 0;
    int          passed_cnt = 0;
    int          beep_cycles;
    int          write_cnt;
    logic        exp_clear = 1'b0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    alarm_tone_generator #(
        .AMPLITUDE       (32'h1000_0000),
        .BEEP_ON_SAMPLES (8),
        .BEEP_OFF_SAMPLES(4)
    ) dut (
        .CLOCK_50               (clk),
        .reset                  (reset),
        .enable                 (enable),
        .half_period            (half_period),
        .volume                 (volume),
        .audio_out_allowed      (allowed),
        .write_audio_out        (write_audio_out),
        .left_channel_audio_out (left_out),
        .right_channel_audio_out(right_out),
        .clear_audio_out_memory (clear_out),
        .beeping                (beeping)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) passed_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic push_tone(input logic [31:0] pk, input int n, input int hp);
        for (int i = 0; i < n; i++)
            exp_q.push_back(((i / hp) % 2 == 0) ? pk : (32'd0 - pk));
    endtask

    task automatic push_zeros(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(32'd0);
    endtask

    // One clock; outputs are sampled on the falling edge, inputs change right after.
    task automatic cycle();
        logic [31:0] e;
        @(posedge clk);
        @(negedge clk);
        check("clear_pulse", 32'(clear_out), 32'(exp_clear));
        check("right_eq_left", right_out, left_out);
        if (beeping) beep_cycles++;
        if (write_audio_out) begin
            write_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_write", 32'(exp_q.size() != 0), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("sample", left_out, e);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drop_and_flush(input string tag);
        enable    = 1'b0;
        exp_clear = 1'b1;
        cycle();
        check({tag, "_write_off"}, 32'(write_audio_out), 32'd0);
        check({tag, "_sample_zero"}, left_out, 32'd0);
        check({tag, "_beeping_off"}, 32'(beeping), 32'd0);
        exp_clear = 1'b0;
        cycle();
        check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        half_period = 16'd2;
        volume      = 2'd3;
        allowed     = 1'b0;
        beep_cycles = 0;
        write_cnt   = 0;

        run(2);
        check("rst_write", 32'(write_audio_out), 32'd0);
        check("rst_sample", left_out, 32'd0);
        check("rst_beeping", 32'(beeping), 32'd0);
        reset = 1'b0;
        run(2);
        check("idle_sample", left_out, 32'd0);

        // Tone shape and repeat, allowed held high.
        allowed = 1'b1;
        enable  = 1'b1;
        push_tone(32'h1000_0000, 8, 2);
        push_zeros(4);
        push_tone(32'h1000_0000, 8, 2);
        beep_cycles = 0;
        run(12);
        check("beeping_cycles", 32'(beep_cycles), 32'd8);
        run(8);
        drop_and_flush("shape");

        // Backpressure with allowed pattern 1-0-0-1.
        begin
            logic        pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
            logic        prev_allowed;
            logic [31:0] prev_left;
            int          k;
            push_tone(32'h1000_0000, 8, 2);
            push_zeros(4);
            write_cnt    = 0;
            k            = 0;
            allowed      = pat[0];
            enable       = 1'b1;
            prev_allowed = 1'b1;
            prev_left    = 32'd0;
            while (write_cnt < 12 && k < 100) begin
                cycle();
                if (!allowed && !prev_allowed) check("hold_sample", left_out, prev_left);
                prev_allowed = allowed;
                prev_left    = left_out;
                k++;
                allowed = pat[k % 4];
            end
            check("bp_write_count", 32'(write_cnt), 32'd12);
            allowed = 1'b1;
            drop_and_flush("bp");
        end

        // Volume latched per burst, then stop mid-burst.
        volume = 2'd1;
        enable = 1'b1;
        push_tone(32'h0400_0000, 8, 2);
        push_zeros(4);
        push_tone(32'h1000_0000, 4, 2);
        run(3);
        volume = 2'd3;
        run(13);
        check("vol_beeping_mid", 32'(beeping), 32'd1);
        drop_and_flush("vol_stop");

        // half_period of zero behaves as one.
        half_period = 16'd0;
        enable      = 1'b1;
        push_tone(32'h1000_0000, 8, 1);
        push_zeros(4);
        run(12);
        drop_and_flush("hp0");
        half_period = 16'd2;

        // Synchronous reset during GAP: no flush, fresh burst after release.
        enable = 1'b1;
        push_tone(32'h1000_0000, 8, 2);
        push_zeros(2);
        run(10);
        check("pre_reset_in_gap", 32'(beeping), 32'd0);
        reset = 1'b1;
        cycle();
        check("rst_gap_write", 32'(write_audio_out), 32'd0);
        check("rst_gap_sample", left_out, 32'd0);
        check("rst_gap_beeping", 32'(beeping), 32'd0);
        cycle();
        check("rst_gap_queue", 32'(exp_q.size()), 32'd0);
        reset = 1'b0;
        push_tone(32'h1000_0000, 8, 2);
        run(8);
        drop_and_flush("post_reset");

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
